// File: rtl/l2_stub_responder_if.sv
// Request/response bus between the L1 caches and the L2 stub responder,
// plus the shared geometry constants and op encodings.
package l2_stub_pkg;
    localparam int CACHE_LINE_BITS  = 512;
    localparam int CACHE_LINE_BYTES = CACHE_LINE_BITS / 8;
    localparam int L2_ADDR_BITS     = 26;
    localparam int NUM_STRANDS      = 4;
    localparam int STRAND_BITS      = 2;
    localparam int UNIT_BITS        = 3;
    localparam int WAY_BITS         = 2;

    typedef enum logic [2:0] {
        L2REQ_LOAD        = 3'd0,
        L2REQ_STORE       = 3'd1,
        L2REQ_FLUSH       = 3'd2,
        L2REQ_IINVALIDATE = 3'd3,
        L2REQ_DINVALIDATE = 3'd4,
        L2REQ_LOAD_SYNC   = 3'd5,
        L2REQ_STORE_SYNC  = 3'd6
    } l2req_op_t;

    typedef enum logic [1:0] {
        L2RSP_LOAD_ACK    = 2'd0,
        L2RSP_STORE_ACK   = 2'd1,
        L2RSP_IINVALIDATE = 2'd2,
        L2RSP_DINVALIDATE = 2'd3
    } l2rsp_op_t;
endpackage

interface l2_stub_responder_if
    import l2_stub_pkg::*;
#(
    parameter int NUM_CORES = 1
) ();
    localparam int CORE_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic                          l2req_valid;
    logic [CORE_BITS-1:0]          l2req_core;
    logic [UNIT_BITS-1:0]          l2req_unit;
    logic [STRAND_BITS-1:0]        l2req_strand;
    l2req_op_t                     l2req_op;
    logic [WAY_BITS-1:0]           l2req_way;
    logic [L2_ADDR_BITS-1:0]       l2req_address;
    logic [CACHE_LINE_BITS-1:0]    l2req_data;
    logic [CACHE_LINE_BYTES-1:0]   l2req_mask;
    logic                          l2req_ready;

    logic                          l2rsp_valid;
    logic                          l2rsp_status;
    logic [CORE_BITS-1:0]          l2rsp_core;
    logic [UNIT_BITS-1:0]          l2rsp_unit;
    logic [STRAND_BITS-1:0]        l2rsp_strand;
    l2rsp_op_t                     l2rsp_op;
    logic [NUM_CORES-1:0]          l2rsp_update;
    logic [NUM_CORES*WAY_BITS-1:0] l2rsp_way;
    logic [L2_ADDR_BITS-1:0]       l2rsp_address;
    logic [CACHE_LINE_BITS-1:0]    l2rsp_data;

    modport master (
        output l2req_valid, l2req_core, l2req_unit, l2req_strand, l2req_op,
               l2req_way, l2req_address, l2req_data, l2req_mask,
        input  l2req_ready,
        input  l2rsp_valid, l2rsp_status, l2rsp_core, l2rsp_unit, l2rsp_strand,
               l2rsp_op, l2rsp_update, l2rsp_way, l2rsp_address, l2rsp_data
    );

    modport slave (
        input  l2req_valid, l2req_core, l2req_unit, l2req_strand, l2req_op,
               l2req_way, l2req_address, l2req_data, l2req_mask,
        output l2req_ready,
        output l2rsp_valid, l2rsp_status, l2rsp_core, l2rsp_unit, l2rsp_strand,
               l2rsp_op, l2rsp_update, l2rsp_way, l2rsp_address, l2rsp_data
    );
endinterface

// File: rtl/l2_stub_responder.sv
// Stand-in for the L2 cache: queues L1 requests, serves them from a small
// line-addressed memory one per cycle, and tracks load/store-sync links per strand.
module l2_stub_responder
    import l2_stub_pkg::*;
#(
    parameter int NUM_CORES     = 1,
    parameter int MEM_ADDR_BITS = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    l2_stub_responder_if.slave bus
);
    localparam int CORE_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS  = PTR_BITS + 1;
    localparam int NUM_LINKS = NUM_CORES * NUM_STRANDS;
    localparam int MEM_LINES = 1 << MEM_ADDR_BITS;

    typedef struct packed {
        logic [CORE_BITS-1:0]        core;
        logic [UNIT_BITS-1:0]        unit;
        logic [STRAND_BITS-1:0]      strand;
        l2req_op_t                   op;
        logic [WAY_BITS-1:0]         way;
        logic [L2_ADDR_BITS-1:0]     address;
        logic [CACHE_LINE_BITS-1:0]  data;
        logic [CACHE_LINE_BYTES-1:0] mask;
    } req_t;

    typedef struct packed {
        logic                          valid;
        logic                          status;
        logic [CORE_BITS-1:0]          core;
        logic [UNIT_BITS-1:0]          unit;
        logic [STRAND_BITS-1:0]        strand;
        l2rsp_op_t                     op;
        logic [NUM_CORES-1:0]          update;
        logic [NUM_CORES*WAY_BITS-1:0] way;
        logic [L2_ADDR_BITS-1:0]       address;
        logic [CACHE_LINE_BITS-1:0]    data;
    } rsp_t;

    req_t                        fifo_mem [FIFO_DEPTH];
    logic [CACHE_LINE_BITS-1:0]  mem [MEM_LINES];

    logic [PTR_BITS-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]         count_q, count_d;
    logic                        ready_q, ready_d;
    logic                        head_valid_q, head_valid_d;
    req_t                        head_q, head_d;
    rsp_t                        rsp_q, rsp_d;
    logic [NUM_LINKS-1:0]        link_valid_q, link_valid_d;
    logic [L2_ADDR_BITS-1:0]     link_addr_q [NUM_LINKS];
    logic [L2_ADDR_BITS-1:0]     link_addr_d [NUM_LINKS];

    logic                        enq, deq;
    req_t                        enq_entry;
    logic [MEM_ADDR_BITS-1:0]    mem_idx;
    logic [CACHE_LINE_BITS-1:0]  old_line, merged_line;
    logic                        mem_we, own_link_hit, do_store;
    logic                        set_own, clear_own, clear_match, is_own;

    // Ready is registered from the post-edge occupancy, so a full queue refuses
    // an accept even on a cycle where the head is leaving.
    always_comb begin
        enq                = bus.l2req_valid && ready_q;
        deq                = (count_q != '0);
        enq_entry.core     = bus.l2req_core;
        enq_entry.unit     = bus.l2req_unit;
        enq_entry.strand   = bus.l2req_strand;
        enq_entry.op       = bus.l2req_op;
        enq_entry.way      = bus.l2req_way;
        enq_entry.address  = bus.l2req_address;
        enq_entry.data     = bus.l2req_data;
        enq_entry.mask     = bus.l2req_mask;
        wr_ptr_d           = wr_ptr_q + PTR_BITS'(enq);
        rd_ptr_d           = rd_ptr_q + PTR_BITS'(deq);
        count_d            = count_q + CNT_BITS'(enq) - CNT_BITS'(deq);
        ready_d            = (count_d < CNT_BITS'(FIFO_DEPTH));
        head_valid_d       = deq;
        head_d             = deq ? fifo_mem[rd_ptr_q] : head_q;
    end

    always_comb begin
        mem_idx  = head_q.address[MEM_ADDR_BITS-1:0];
        old_line = mem[mem_idx];
        for (int b = 0; b < CACHE_LINE_BYTES; b++) begin
            merged_line[8*b +: 8] = head_q.mask[b] ? head_q.data[8*b +: 8] : old_line[8*b +: 8];
        end

        own_link_hit = 1'b0;
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int s = 0; s < NUM_STRANDS; s++) begin
                if (head_q.core == CORE_BITS'(c) && head_q.strand == STRAND_BITS'(s) &&
                    link_valid_q[c*NUM_STRANDS+s] && link_addr_q[c*NUM_STRANDS+s] == head_q.address) begin
                    own_link_hit = 1'b1;
                end
            end
        end

        do_store     = 1'b0;
        set_own      = 1'b0;
        clear_own    = 1'b0;
        clear_match  = 1'b0;
        is_own       = 1'b0;
        mem_we       = 1'b0;
        rsp_d        = '0;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;

        if (head_valid_q) begin
            rsp_d.valid   = 1'b1;
            rsp_d.status  = 1'b1;
            rsp_d.core    = head_q.core;
            rsp_d.unit    = head_q.unit;
            rsp_d.strand  = head_q.strand;
            rsp_d.address = head_q.address;
            rsp_d.data    = old_line;
            for (int c = 0; c < NUM_CORES; c++) begin
                if (head_q.core == CORE_BITS'(c)) begin
                    rsp_d.way[c*WAY_BITS +: WAY_BITS] = head_q.way;
                end
            end

            case (head_q.op)
                L2REQ_LOAD:        rsp_d.op = L2RSP_LOAD_ACK;
                L2REQ_LOAD_SYNC: begin
                    rsp_d.op = L2RSP_LOAD_ACK;
                    set_own  = 1'b1;
                end
                L2REQ_STORE:       do_store = 1'b1;
                L2REQ_STORE_SYNC: begin
                    clear_own = 1'b1;
                    if (own_link_hit) begin
                        do_store = 1'b1;
                    end else begin
                        rsp_d.op     = L2RSP_STORE_ACK;
                        rsp_d.status = 1'b0;
                    end
                end
                L2REQ_DINVALIDATE: begin
                    rsp_d.op     = L2RSP_DINVALIDATE;
                    rsp_d.update = '1;
                    clear_match  = 1'b1;
                end
                L2REQ_IINVALIDATE: rsp_d.op = L2RSP_IINVALIDATE;
                L2REQ_FLUSH:       rsp_d.op = L2RSP_STORE_ACK;
                default:           rsp_d.op = L2RSP_LOAD_ACK;
            endcase

            if (do_store) begin
                mem_we      = 1'b1;
                rsp_d.op    = L2RSP_STORE_ACK;
                rsp_d.data  = merged_line;
                clear_match = 1'b1;
                for (int c = 0; c < NUM_CORES; c++) begin
                    if (head_q.core == CORE_BITS'(c)) begin
                        rsp_d.update[c] = 1'b1;
                    end
                end
            end

            // Any write to a linked address breaks that link for every strand.
            for (int c = 0; c < NUM_CORES; c++) begin
                for (int s = 0; s < NUM_STRANDS; s++) begin
                    is_own = (head_q.core == CORE_BITS'(c)) && (head_q.strand == STRAND_BITS'(s));
                    if (clear_match && link_addr_q[c*NUM_STRANDS+s] == head_q.address) begin
                        link_valid_d[c*NUM_STRANDS+s] = 1'b0;
                    end
                    if (is_own && set_own) begin
                        link_valid_d[c*NUM_STRANDS+s] = 1'b1;
                        link_addr_d[c*NUM_STRANDS+s]  = head_q.address;
                    end
                    if (is_own && clear_own) begin
                        link_valid_d[c*NUM_STRANDS+s] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b1;
            head_valid_q <= 1'b0;
            head_q       <= '0;
            rsp_q        <= '0;
            link_valid_q <= '0;
            link_addr_q  <= '{default: '0};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
            rsp_q        <= rsp_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    // Queue slots and backing lines hold data only; neither is cleared by reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem[wr_ptr_q] <= enq_entry;
        end
        if (mem_we) begin
            mem[mem_idx] <= merged_line;
        end
    end

    assign bus.l2req_ready   = ready_q;
    assign bus.l2rsp_valid   = rsp_q.valid;
    assign bus.l2rsp_status  = rsp_q.status;
    assign bus.l2rsp_core    = rsp_q.core;
    assign bus.l2rsp_unit    = rsp_q.unit;
    assign bus.l2rsp_strand  = rsp_q.strand;
    assign bus.l2rsp_op      = rsp_q.op;
    assign bus.l2rsp_update  = rsp_q.update;
    assign bus.l2rsp_way     = rsp_q.way;
    assign bus.l2rsp_address = rsp_q.address;
    assign bus.l2rsp_data    = rsp_q.data;
endmodule
